gpr_snapshot_rx: RTL and testbench

GPR_SNAPSHOT_RX -- requirements
Module: gpr_snapshot_rx

---
 rtl/gpr_snapshot_rx.sv | 127 ++++++++++++
 tb/tb_gpr_snapshot_rx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/gpr_snapshot_rx.sv
// gpr_snapshot_rx: collects GPR snapshot flits into a buffer and re-emits them
// as a header flit followed by 16-bit data flits.
module gpr_snapshot_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [2:0]            in_type,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [15:0]           out_flit,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int CW = $clog2(MAX_REGS + 1);
  localparam int IW = (MAX_REGS > 1) ? $clog2(MAX_REGS) : 1;
  localparam logic [2:0] T_NONE = 3'd0, T_SINGLE = 3'd1, T_FIRST = 3'd2, T_MIDDLE = 3'd3, T_LAST = 3'd4;
  typedef enum logic [1:0] {IDLE, COLLECT, EMIT_HDR, EMIT_DATA} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d, rd_q, rd_d;
  logic            half_q, half_d, ovf_q, ovf_d, perr_q, perr_d;
  logic [7:0]      seq_q, seq_d;
  logic            wr_en;
  logic [IW-1:0]   wr_idx;
  logic [DATA_WIDTH-1:0] mem [MAX_REGS];
  logic [31:0]     word;
  logic            in_acc, out_hs, full, last_word;
  assign in_acc    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign full      = count_q == CW'(MAX_REGS);
  assign last_word = rd_q == count_q - CW'(1);
  assign word      = 32'(mem[rd_q[IW-1:0]]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      rd_q    <= '0;
      half_q  <= 1'b0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      half_q  <= half_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
      seq_q   <= seq_d;
    end
  end
  // Buffer contents survive reset; only the bookkeeping is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= in_data;
  end
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rd_d    = rd_q;
    half_d  = half_q;
    ovf_d   = ovf_q;
    perr_d  = perr_q;
    seq_d   = seq_q;
    wr_en   = 1'b0;
    wr_idx  = count_q[IW-1:0];
    case (state_q)
      IDLE: if (in_acc) begin
        if (in_type == T_SINGLE || in_type == T_FIRST) begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          count_d = CW'(1);
          state_d = (in_type == T_SINGLE) ? EMIT_HDR : COLLECT;
        end else if (in_type == T_NONE) begin
          count_d = '0;
          state_d = EMIT_HDR;
        end else perr_d = 1'b1;
      end
      COLLECT: if (in_acc) begin
        if (in_type == T_MIDDLE || in_type == T_LAST) begin
          wr_en   = !full;
          count_d = full ? count_q : count_q + CW'(1);
          ovf_d   = ovf_q | full;
          if (in_type == T_LAST) state_d = EMIT_HDR;
        end else if (in_type == T_FIRST) begin
          perr_d  = 1'b1;
          ovf_d   = 1'b0;
          wr_en   = 1'b1;
          wr_idx  = '0;
          count_d = CW'(1);
        end else if (in_type == T_SINGLE || in_type == T_NONE) begin
          perr_d  = 1'b1;
          state_d = EMIT_HDR;
        end else perr_d = 1'b1;
      end
      EMIT_HDR: if (out_hs) begin
        rd_d    = '0;
        half_d  = 1'b0;
        state_d = (count_q == '0) ? IDLE : EMIT_DATA;
      end
      EMIT_DATA: if (out_hs) begin
        half_d = !half_q;
        if (half_q) rd_d = rd_q + CW'(1);
        if (half_q && last_word) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && state_d == IDLE) begin
      seq_d   = seq_q + 8'd1;
      ovf_d   = 1'b0;
      perr_d  = 1'b0;
      count_d = '0;
      rd_d    = '0;
      half_d  = 1'b0;
    end
  end
  always_comb begin
    in_ready  = state_q == IDLE || state_q == COLLECT;
    out_valid = state_q == EMIT_HDR || state_q == EMIT_DATA;
    out_last  = (state_q == EMIT_HDR) ? (count_q == '0) :
                (state_q == EMIT_DATA) ? (half_q && last_word) : 1'b0;
    out_flit  = (state_q == EMIT_HDR) ? {6'(count_q), ovf_q, perr_q, seq_q} :
                (state_q == EMIT_DATA) ? (half_q ? word[31:16] : word[15:0]) : 16'h0000;
  end
endmodule

// File: tb/tb_gpr_snapshot_rx.sv
// tb_gpr_snapshot_rx: scoreboard bench; a protocol model predicts every output
// flit as stimulus is accepted, a negedge monitor pops and compares.
module tb_gpr_snapshot_rx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [2:0]  in_type;
  logic        in_valid, in_ready;
  logic [15:0] out_flit;
  logic        out_last, out_valid, out_ready;
  int          n_checks = 0, n_errors = 0;
  int          rdy_mode = 0;
  logic [16:0] sb [$];
  logic [31:0] m_words [$];
  logic        m_coll, m_ovf, m_perr;
  logic [7:0]  m_seq;
  logic        stalled = 1'b0;
  logic [16:0] held;

  gpr_snapshot_rx dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_type(in_type),
    .in_valid(in_valid), .in_ready(in_ready), .out_flit(out_flit),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_coll = 1'b0; m_ovf = 1'b0; m_perr = 1'b0; m_seq = 8'd0;
    m_words.delete();
  endtask

  task automatic m_close();
    logic [5:0] c;
    c = 6'(m_words.size());
    sb.push_back({m_words.size() == 0, c, m_ovf, m_perr, m_seq});
    foreach (m_words[i]) begin
      sb.push_back({1'b0, m_words[i][15:0]});
      sb.push_back({i == m_words.size() - 1, m_words[i][31:16]});
    end
    m_seq++; m_ovf = 1'b0; m_perr = 1'b0; m_coll = 1'b0;
    m_words.delete();
  endtask

  task automatic m_append(input logic [31:0] d);
    if (m_words.size() == 32) m_ovf = 1'b1;
    else m_words.push_back(d);
  endtask

  task automatic send(input logic [2:0] t, input logic [31:0] d);
    int  n = 0;
    bit  closed = 0;
    @(negedge clk);
    in_valid = 1'b1; in_type = t; in_data = d;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "stuck");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_type  = 3'($urandom_range(0, 7));
    in_data  = $urandom;
    if (!m_coll) begin
      case (t)
        3'd1: begin m_words.push_back(d); m_close(); closed = 1; end
        3'd2: begin m_words.push_back(d); m_coll = 1'b1; end
        3'd0: begin m_close(); closed = 1; end
        default: m_perr = 1'b1;
      endcase
    end else begin
      case (t)
        3'd3: m_append(d);
        3'd4: begin m_append(d); m_close(); closed = 1; end
        3'd2: begin m_perr = 1'b1; m_ovf = 1'b0; m_words.delete(); m_words.push_back(d); end
        3'd0, 3'd1: begin m_perr = 1'b1; m_close(); closed = 1; end
        default: m_perr = 1'b1;
      endcase
    end
    if (closed) chk("hdr_latency", {31'd0, out_valid}, 32'd1);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ~out_ready : 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (stalled) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_flit", {15'd0, out_last, out_flit}, {15'd0, held});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_flit", {15'd0, out_last, out_flit}, 32'hFFFF_FFFF);
        else chk("flit", {15'd0, out_last, out_flit}, {15'd0, sb.pop_front()});
      end
      stalled = out_valid && !out_ready;
      held    = {out_last, out_flit};
    end else stalled = 1'b0;
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_type = 3'd0; in_data = '0; out_ready = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_flit", {16'd0, out_flit}, 32'd0);
    rst_n = 1'b1;
    send(3'd1, 32'hDEAD_BEEF);
    send(3'd1, 32'h1234_5678);
    rdy_mode = 1;
    send(3'd2, 32'h1111_1111);
    send(3'd3, 32'h2222_2222);
    send(3'd4, 32'h3333_3333);
    rdy_mode = 0;
    for (int i = 0; i < 257; i++) send(3'd0, $urandom);
    rdy_mode = 2;
    send(3'd2, 32'hA000_0000);
    for (int i = 1; i < 32; i++) send(3'd3, 32'hA000_0000 | i);
    send(3'd4, 32'hA000_0020);
    send(3'd4, 32'h0);
    send(3'd1, 32'h5);
    send(3'd2, 32'h0);
    send(3'd2, 32'hA);
    send(3'd4, 32'hB);
    send(3'd6, 32'h0);
    send(3'd2, 32'h0101_0202);
    send(3'd1, 32'h0303_0404);
    send(3'd2, 32'h0505_0606);
    send(3'd7, 32'h0);
    send(3'd0, 32'h0707_0808);
    rdy_mode = 1;
    send(3'd2, 32'hAAAA_BBBB);
    send(3'd4, 32'hCCCC_DDDD);
    n = 0;
    while (sb.size() > 3 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("reach_emit_data", sb.size(), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out_flit", {15'd0, out_last, out_flit}, 32'd0);
    sb.delete();
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    send(3'd1, 32'h0000_1234);
    n = 0;
    while (sb.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 32'd0);
    repeat (3) @(negedge clk);
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
